// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller:
// FSM state encoding and forwarding select encodings.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one EX operand.
// The MEM result is younger than WB, so it takes priority.
module fwd_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REGADDR_WIDTH = 5
) (
    input  logic [REGADDR_WIDTH-1:0] rs_addr,
    input  logic [REGADDR_WIDTH-1:0] rd_addr_mem,
    input  logic                     regs_write_mem,
    input  logic [REGADDR_WIDTH-1:0] rd_addr_wb,
    input  logic                     regs_write_wb,
    output logic [1:0]               sel
);

    logic hit_mem;
    logic hit_wb;

    assign hit_mem = regs_write_mem && (rd_addr_mem != '0)
                     && (rd_addr_mem == rs_addr);
    assign hit_wb  = regs_write_wb && (rd_addr_wb != '0)
                     && (rd_addr_wb == rs_addr);

    always_comb begin
        sel = FWD_REGFILE;
        if (hit_mem) begin
            sel = FWD_MEM;
        end else if (hit_wb) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: data-RAM wait, branch flush,
// load-use stall, operand forwarding and a stall cycle counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REGADDR_WIDTH = 5,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REGADDR_WIDTH-1:0] rs1_addr_id,
    input  logic [REGADDR_WIDTH-1:0] rs2_addr_id,
    input  logic [REGADDR_WIDTH-1:0] rs1_addr_ex,
    input  logic [REGADDR_WIDTH-1:0] rs2_addr_ex,
    input  logic [REGADDR_WIDTH-1:0] rd_addr_ex,
    input  logic                     ram_read_ex,
    input  logic                     regs_write_ex,
    input  logic [REGADDR_WIDTH-1:0] rd_addr_mem,
    input  logic [REGADDR_WIDTH-1:0] rd_addr_wb,
    input  logic                     regs_write_mem,
    input  logic                     regs_write_wb,
    input  logic                     ram_req_mem,
    input  logic                     ram_ready,
    input  logic                     branch_taken_ex,
    output logic                     pc_en,
    output logic                     if_id_en,
    output logic                     id_ex_en,
    output logic                     ex_mem_en,
    output logic                     mem_wb_en,
    output logic                     if_id_flush,
    output logic                     id_ex_flush,
    output logic                     mem_wb_bubble,
    output logic [1:0]               fwd_a_sel,
    output logic [1:0]               fwd_b_sel,
    output logic [CNT_WIDTH-1:0]     stall_cnt
);

    state_t state;
    state_t state_nxt;

    logic mem_stall;
    logic load_use;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    assign mem_stall = ram_req_mem && !ram_ready;
    assign load_use  = ram_read_ex && regs_write_ex
                       && (rd_addr_ex != '0)
                       && ((rd_addr_ex == rs1_addr_id)
                           || (rd_addr_ex == rs2_addr_id));

    fwd_unit #(.REGADDR_WIDTH(REGADDR_WIDTH)) u_fwd_a (
        .rs_addr        (rs1_addr_ex),
        .rd_addr_mem    (rd_addr_mem),
        .regs_write_mem (regs_write_mem),
        .rd_addr_wb     (rd_addr_wb),
        .regs_write_wb  (regs_write_wb),
        .sel            (sel_a)
    );

    fwd_unit #(.REGADDR_WIDTH(REGADDR_WIDTH)) u_fwd_b (
        .rs_addr        (rs2_addr_ex),
        .rd_addr_mem    (rd_addr_mem),
        .regs_write_mem (regs_write_mem),
        .rd_addr_wb     (rd_addr_wb),
        .regs_write_wb  (regs_write_wb),
        .sel            (sel_b)
    );

    assign fwd_a_sel = rst ? FWD_REGFILE : sel_a;
    assign fwd_b_sel = rst ? FWD_REGFILE : sel_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_en     = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;

        if (rst) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN, LU_STALL: begin
                    state_nxt = RUN;
                    if (mem_stall) begin
                        // Freeze the front, drain a no-op into WB.
                        mem_wb_en     = 1'b1;
                        mem_wb_bubble = 1'b1;
                        state_nxt     = MEM_WAIT;
                    end else begin
                        pc_en     = 1'b1;
                        if_id_en  = 1'b1;
                        id_ex_en  = 1'b1;
                        ex_mem_en = 1'b1;
                        mem_wb_en = 1'b1;
                        if (branch_taken_ex) begin
                            if_id_flush = 1'b1;
                            id_ex_flush = 1'b1;
                        end else if (load_use && state == RUN) begin
                            pc_en       = 1'b0;
                            if_id_en    = 1'b0;
                            id_ex_flush = 1'b1;
                            state_nxt   = LU_STALL;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (!ram_ready) begin
                        mem_wb_en     = 1'b1;
                        mem_wb_bubble = 1'b1;
                    end else begin
                        pc_en       = 1'b1;
                        if_id_en    = 1'b1;
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        if_id_flush = branch_taken_ex;
                        id_ex_flush = branch_taken_ex;
                        state_nxt   = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!pc_en && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REGADDR_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, stall counter width.
REQ-003 SHALL have the following ports, one clock, with reset synchronous and active-high:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- rs1_addr_id, rs2_addr_id  in  REGADDR_WIDTH  ID-stage sources.
- rs1_addr_ex, rs2_addr_ex, rd_addr_ex  in  REGADDR_WIDTH  EX-stage addresses.
- ram_read_ex, regs_write_ex  in  1  EX-stage controls.
- rd_addr_mem, rd_addr_wb  in  REGADDR_WIDTH  MEM/WB destinations.
- regs_write_mem, regs_write_wb  in  1  MEM/WB write enables.
- ram_req_mem  in  1  MEM-stage data RAM access (read or write).
- ram_ready  in  1  data RAM completes access this cycle.
- branch_taken_ex  in  1  EX resolved a taken branch or jump.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  stage register enables.
- if_id_flush, id_ex_flush  out  1  load a bubble into the stage register.
- mem_wb_bubble  out  1  MEM/WB loads a no-op (all controls 0).
- fwd_a_sel, fwd_b_sel  out  2  EX operand source: 00 regfile, 01 WB, 10 MEM.
- stall_cnt  out  CNT_WIDTH  count of cycles with pc_en=0.

Function
REQ-004 SHALL implement the FSM states RUN, LU_STALL and MEM_WAIT.
REQ-005 Hazard priority SHALL be MEM_WAIT condition, then branch flush, then load-use.
REQ-006 Mem wait, in RUN: when ram_req_mem=1 and ram_ready=0, all five enables SHALL be 0 and mem_wb_bubble SHALL be 1 with mem_wb_en forced to 1. The next state SHALL be MEM_WAIT.
REQ-007 In MEM_WAIT, with ram_ready=0: the REQ-006 outputs SHALL hold. With ram_ready=1: all enables SHALL be 1 and mem_wb_bubble SHALL be 0 that same cycle. The next state SHALL be RUN.
REQ-008 Branch: a taken branch in RUN, or in the MEM_WAIT release cycle, SHALL assert if_id_flush and id_ex_flush for exactly that cycle, with enables at 1.
REQ-009 Branch overrides load-use: there SHALL be no stall and no LU_STALL entry.
REQ-010 Load-use: in RUN, with no branch, the condition is ram_read_ex and regs_write_ex and rd_addr_ex != 0 and rd_addr_ex equal to rs1_addr_id or rs2_addr_id. When it holds, pc_en and if_id_en SHALL be 0 and id_ex_flush SHALL be 1. The next state SHALL be LU_STALL.
REQ-011 LU_STALL SHALL last exactly one cycle, with outputs as in RUN without a load-use re-check, then return to RUN. A MEM_WAIT condition in LU_STALL SHALL go to MEM_WAIT.
REQ-012 Forwarding for A (B is identical with rs2):
- fwd_a_sel SHALL be 10 if regs_write_mem, rd_addr_mem != 0 and rd_addr_mem == rs1_addr_ex.
- Otherwise it SHALL be 01 if the same holds for WB.
- Otherwise it SHALL be 00.
- It SHALL be combinational and valid in all states.
REQ-013 Register x0 SHALL never cause a stall or a forward.
REQ-014 stall_cnt SHALL increment by 1 on each cycle with pc_en=0, saturate at all-ones, and never wrap.
REQ-015 With no hazard in RUN, all enables SHALL be 1 and all flush and bubble outputs SHALL be 0.

Reset
REQ-016 While rst=1: state SHALL be RUN next cycle, stall_cnt SHALL be 0, all enables, flushes and bubble SHALL be 0, and fwd selects SHALL be 00.
REQ-017 A reset asserted in MEM_WAIT or LU_STALL SHALL abandon the wait. The first cycle after rst falls SHALL evaluate from RUN.

Structure
REQ-018 Package pipe_ctrl_pkg SHALL hold the FSM state enum and the FWD_REGFILE/FWD_WB/FWD_MEM encodings.
REQ-019 A sub-module fwd_unit SHALL compute one forwarding select and SHALL be instantiated twice, once for A and once for B.

Verification
REQ-020 Load-use stall: rd_addr_ex=5, ram_read_ex=1, regs_write_ex=1, rs2_addr_id=5 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1, then RUN; stall_cnt +1.
REQ-021 MEM wait: ram_req_mem=1, ram_ready=0 for 3 cycles, then 1 -> enables 0 and mem_wb_bubble=1 for 3 cycles, release on cycle 4; stall_cnt +3.
REQ-022 Branch vs load-use: branch_taken_ex=1 with a load-use match -> if_id_flush=1, id_ex_flush=1, pc_en=1, no LU_STALL.
REQ-023 Forwarding priority: rd_addr_mem=rd_addr_wb=rs1_addr_ex=7, both writes=1 -> fwd_a_sel=10; with regs_write_mem=0 -> 01; with rd=0 -> 00.
REQ-024 Reset mid-wait: rst=1 during MEM_WAIT -> outputs 0; after release with ram_req_mem=0 -> enables 1, stall_cnt=0.
REQ-025 Saturation: CNT_WIDTH=4, hold ram_ready=0 for 20 cycles -> stall_cnt stops at 15.
